// File: rtl/ctrl_encode_def.sv
// Encodings shared between the fetch unit and the controller:
// next-PC selectors and instruction field positions.
package ctrl_encode_def;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM16_MSB = 15;
   localparam int IMM26_MSB = 25;

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC selection for the retiring instruction.
// misalign flags a JR whose register target is not word aligned.
module npc_calc
   import ctrl_encode_def::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] pc_out,
   input  logic [31:0]   inst,
   input  logic [1:0]    npc_op,
   input  logic [31:0]   rs_data,
   output logic [AW-1:0] npc,
   output logic          misalign
);

   logic [AW-1:0] p4_s;
   logic [AW-1:0] br_off_s;
   logic          unused_op_s;

   assign unused_op_s = ^inst[OP_MSB:OP_LSB];

   // Select the successor address; p4 is aligned because pc_out always is.
   always_comb begin
      p4_s     = pc_out + AW'(32'd4);
      br_off_s = {{(AW-18){inst[IMM16_MSB]}}, inst[IMM16_MSB:0], 2'b00};
      npc      = p4_s;
      misalign = 1'b0;
      case (npc_op)
         NPC_PLUS4:  npc = p4_s;
         NPC_BRANCH: npc = p4_s + br_off_s;
         NPC_JUMP:   npc = {p4_s[AW-1:28], inst[IMM26_MSB:0], 2'b00};
         NPC_JR: begin
            npc      = {rs_data[AW-1:2], 2'b00};
            misalign = (rs_data[1:0] != 2'b00);
         end
         default:    npc = p4_s;
      endcase
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, holds the fetched word
// for decode until consumed, then advances the PC by the resolved NPCOp.
module ifu_fetch
   import ctrl_encode_def::*;
#(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst,
   output logic [AW-1:0] pc_out,
   output logic [5:0]    Op,
   output logic [5:0]    Funct,
   input  logic [1:0]    NPCOp,
   input  logic [31:0]   rs_data,
   output logic          addr_err,
   output logic [31:0]   retired
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pc_out_q, pc_out_d;
   logic [31:0]   inst_q, inst_d;
   logic [31:0]   retired_q, retired_d;
   logic          addr_err_q, addr_err_d;
   logic [AW-1:0] npc_s;
   logic          misalign_s;

   npc_calc #(.AW(AW)) u_npc_calc (
      .pc_out   (pc_out_q),
      .inst     (inst_q),
      .npc_op   (NPCOp),
      .rs_data  (rs_data),
      .npc      (npc_s),
      .misalign (misalign_s)
   );

   // Handshake sequencing and the register updates each state owns.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_out_d   = pc_out_q;
      inst_d     = inst_q;
      retired_d  = retired_q;
      addr_err_d = addr_err_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_gnt) state_d = S_WAIT;
            else          state_d = S_REQ;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               inst_d   = imem_rdata;
               pc_out_d = pc_q;
               state_d  = S_HOLD;
            end else begin
               state_d  = S_WAIT;
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               pc_d       = npc_s;
               retired_d  = retired_q + 32'd1;
               addr_err_d = addr_err_q | misalign_s;
               state_d    = S_REQ;
            end else begin
               state_d    = S_HOLD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         pc_out_q   <= {AW{1'b0}};
         inst_q     <= 32'h0000_0000;
         retired_q  <= 32'h0000_0000;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_out_q   <= pc_out_d;
         inst_q     <= inst_d;
         retired_q  <= retired_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign imem_req   = (state_q == S_REQ);
   assign inst_valid = (state_q == S_HOLD);
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign pc_out     = pc_out_q;
   assign Op         = inst_q[OP_MSB:OP_LSB];
   assign Funct      = inst_q[FUNCT_MSB:FUNCT_LSB];
   assign addr_err   = addr_err_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: drives imem and decode handshakes at the
// falling edge and checks against hand-computed addresses and counts.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc_out;
   logic [5:0]  Op;
   logic [5:0]  Funct;
   logic [1:0]  npc_op;
   logic [31:0] rs_data;
   logic        addr_err;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ifu_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .pc_out      (pc_out),
      .Op          (Op),
      .Funct       (Funct),
      .NPCOp       (npc_op),
      .rs_data     (rs_data),
      .addr_err    (addr_err),
      .retired     (retired)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      inst_ready = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_req(input string name, input logic [31:0] exp_addr);
      bit ok = 1'b0;
      bit dup = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (imem_req === 1'b1) begin ok = 1'b1; break; end
         if (inst_valid !== 1'b0) dup = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL %s req_timeout: imem_req=%b required 1", name, imem_req);
      end else begin
         checks++;
         if (imem_addr !== exp_addr) begin
            errors++; $display("FAIL %s req_addr: got %h required %h", name, imem_addr, exp_addr);
         end
      end
      checks++;
      if (dup) begin
         errors++; $display("FAIL %s no_dup_valid: inst_valid=1 required 0 before request", name);
      end
   endtask

   task automatic fetch_one(input string name, input logic [31:0] exp_addr, input logic [31:0] word,
                            input int gnt_dly, input int rdy_dly, input logic [1:0] op,
                            input logic [31:0] rs, output int vcyc);
      logic [31:0] ret0;
      wait_req(name, exp_addr);
      ret0 = retired;
      for (int i = 0; i < gnt_dly; i++) begin
         imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0) begin
            errors++; $display("FAIL %s req_stall: req=%b addr=%h valid=%b required 1 %h 0",
                              name, imem_req, imem_addr, inst_valid, exp_addr);
         end
      end
      imem_rvalid = 1'b0;
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL %s wait_state: req=%b valid=%b required 0 0", name, imem_req, inst_valid);
      end
      imem_rvalid = 1'b1; imem_rdata = word;
      @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      vcyc = cyc;
      checks++;
      if (inst_valid !== 1'b1 || inst !== word || pc_out !== exp_addr) begin
         errors++; $display("FAIL %s hold: valid=%b inst=%h pc_out=%h required 1 %h %h",
                           name, inst_valid, inst, pc_out, word, exp_addr);
      end
      checks++;
      if (Op !== word[31:26] || Funct !== word[5:0]) begin
         errors++; $display("FAIL %s fields: Op=%h Funct=%h required %h %h",
                           name, Op, Funct, word[31:26], word[5:0]);
      end
      for (int i = 0; i < rdy_dly; i++) begin
         imem_gnt = 1'b1;
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || inst !== word || pc_out !== exp_addr || retired !== ret0) begin
            errors++; $display("FAIL %s hold_stall: valid=%b inst=%h pc_out=%h retired=%0d required 1 %h %h %0d",
                              name, inst_valid, inst, pc_out, retired, word, exp_addr, ret0);
         end
      end
      imem_gnt = 1'b0;
      npc_op = op; rs_data = rs; inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0; npc_op = 2'b00; rs_data = 32'hFFFF_FFFF;
      checks++;
      if (retired !== ret0 + 32'd1) begin
         errors++; $display("FAIL %s retire: retired=%0d required %0d", name, retired, ret0 + 32'd1);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || Op !== 6'd0 || Funct !== 6'd0) begin
         errors++; $display("FAIL reset_outputs: req=%b valid=%b Op=%h Funct=%h required 0 0 0 0",
                           imem_req, inst_valid, Op, Funct);
      end
      checks++;
      if (retired !== 32'd0 || addr_err !== 1'b0 || imem_addr !== 32'h0000_3000 || inst !== 32'd0) begin
         errors++; $display("FAIL reset_state: retired=%0d err=%b addr=%h inst=%h required 0 0 00003000 0",
                           retired, addr_err, imem_addr, inst);
      end
   endtask

   task automatic test_sequential();
      int v0, v1, v2;
      fetch_one("seq0", 32'h0000_3000, 32'h0001_1020, 0, 0, 2'b00, 32'h0, v0);
      fetch_one("seq1", 32'h0000_3004, 32'h0002_2022, 0, 0, 2'b00, 32'h0, v1);
      fetch_one("seq2", 32'h0000_3008, 32'h0003_3024, 0, 0, 2'b00, 32'h0, v2);
      checks++;
      if (v1 - v0 != 3 || v2 - v1 != 3) begin
         errors++; $display("FAIL seq_spacing: gaps %0d %0d required 3 3", v1 - v0, v2 - v1);
      end
      checks++;
      if (retired !== 32'd3) begin
         errors++; $display("FAIL seq_retired: retired=%0d required 3", retired);
      end
   endtask

   task automatic test_branch();
      int v;
      fetch_one("br_p4",   32'h0000_300C, 32'h0000_0000, 0, 0, 2'b00, 32'h0, v);
      fetch_one("br_self", 32'h0000_3010, 32'h1000_FFFF, 0, 0, 2'b01, 32'h0, v);
      fetch_one("br_back", 32'h0000_3010, 32'h1000_FFFE, 0, 0, 2'b01, 32'h0, v);
      fetch_one("br_fwd",  32'h0000_300C, 32'h1000_0003, 0, 0, 2'b01, 32'h0, v);
      wait_req("br_target", 32'h0000_301C);
      checks++;
      if (retired !== 32'd7) begin
         errors++; $display("FAIL br_retired: retired=%0d required 7", retired);
      end
   endtask

   task automatic test_jump_jr();
      int v;
      do_reset();
      fetch_one("jump", 32'h0000_3000, 32'h0800_0C40, 0, 0, 2'b10, 32'h0, v);
      checks++;
      if (addr_err !== 1'b0) begin
         errors++; $display("FAIL jump_err: addr_err=%b required 0", addr_err);
      end
      fetch_one("jr", 32'h0000_3100, 32'h03E0_0008, 0, 0, 2'b11, 32'h0000_3022, v);
      checks++;
      if (addr_err !== 1'b1) begin
         errors++; $display("FAIL jr_err: addr_err=%b required 1", addr_err);
      end
      for (int i = 0; i < 10; i++) begin
         fetch_one("jr_after", 32'h0000_3020 + 32'(4 * i), 32'h0000_0000, 0, 0, 2'b00, 32'h0, v);
      end
      checks++;
      if (addr_err !== 1'b1 || retired !== 32'd12) begin
         errors++; $display("FAIL jr_sticky: addr_err=%b retired=%0d required 1 12", addr_err, retired);
      end
   endtask

   task automatic test_stall();
      int v;
      do_reset();
      fetch_one("stall", 32'h0000_3000, 32'h8C01_0004, 4, 3, 2'b11, 32'h0000_4000, v);
      checks++;
      if (retired !== 32'd1 || addr_err !== 1'b0) begin
         errors++; $display("FAIL stall_state: retired=%0d addr_err=%b required 1 0", retired, addr_err);
      end
      wait_req("stall_jr", 32'h0000_4000);
   endtask

   task automatic test_reset_in_wait();
      int v;
      do_reset();
      fetch_one("rw_pre", 32'h0000_3000, 32'h0000_0020, 0, 0, 2'b00, 32'h0, v);
      wait_req("rw_req", 32'h0000_3004);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || retired !== 32'd0 || imem_addr !== 32'h0000_3000) begin
         errors++; $display("FAIL rw_abort: req=%b valid=%b retired=%0d addr=%h required 0 0 0 00003000",
                           imem_req, inst_valid, retired, imem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      fetch_one("rw_post", 32'h0000_3000, 32'h0000_0024, 0, 0, 2'b00, 32'h0, v);
   endtask

   initial begin
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      inst_ready = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
      test_reset();
      test_sequential();
      test_branch();
      test_jump_jr();
      test_stall();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
